// File: rtl/gshare_predictor.sv
// gshare_predictor
//   Table of CTR_BITS-wide saturating counters indexed by PC (MODE 0),
//   global history (MODE 1) or their XOR (MODE 2, also any other value).
//   Up to DEPTH predictions may be in flight. An in-order FIFO remembers
//   each one's table index and predicted bit until its result arrives.
//
// Ports
//   clk, rst_n      clock and asynchronous active-low reset
//   request, pc     predict the branch at pc this cycle
//   result, taken   resolve the oldest outstanding prediction
//   prediction      registered predicted direction
//   pred_valid      one-cycle pulse when prediction holds a new result
//   full            FIFO holds DEPTH entries
//   outstanding     current FIFO occupancy
//   mispredict_cnt  saturating count of resolved mispredictions
module gshare_predictor #(
  parameter int PC_BITS   = 32,
  parameter int IDX_BITS  = 8,
  parameter int HIST_BITS = 8,
  parameter int CTR_BITS  = 2,
  parameter logic [CTR_BITS-1:0] CTR_INIT = '1,
  parameter int DEPTH     = 4,
  parameter int MODE      = 2,
  parameter int CNT_BITS  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     request,
  input  logic [PC_BITS-1:0]       pc,
  input  logic                     result,
  input  logic                     taken,
  output logic                     prediction,
  output logic                     pred_valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic [CNT_BITS-1:0]      mispredict_cnt
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int ENTRIES  = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX   = '1;
  localparam logic [CNT_BITS-1:0] CNT_MAX   = '1;
  localparam logic [PTR_BITS:0]   DEPTH_OCC = (PTR_BITS+1)'(DEPTH);

  logic [CTR_BITS-1:0] ctr_table [ENTRIES];
  logic [HIST_BITS-1:0] history;

  logic [IDX_BITS-1:0] fifo_idx  [DEPTH];
  logic                fifo_pred [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;

  logic [IDX_BITS-1:0]  pc_idx;
  logic [IDX_BITS-1:0]  hist_ext;
  logic [IDX_BITS-1:0]  index;
  logic                 pop;
  logic                 accept;
  logic [IDX_BITS-1:0]  pop_idx;
  logic                 pop_pred;
  logic [CTR_BITS-1:0]  old_ctr;
  logic [CTR_BITS-1:0]  new_ctr;
  logic [HIST_BITS-1:0] hist_next;
  logic [PTR_BITS:0]    occ_next;
  logic                 new_pred;
  logic                 unused_pc_bits;

  // Only the word-aligned index bits of pc matter.
  assign unused_pc_bits = ^{pc[PC_BITS-1:IDX_BITS+2], pc[1:0]};

  assign pc_idx   = pc[IDX_BITS+1:2];
  assign hist_ext = IDX_BITS'(history);

  // Index selection; unknown modes fall back to gshare.
  always_comb begin
    index = pc_idx ^ hist_ext;
    case (MODE)
      0:       index = pc_idx;
      1:       index = hist_ext;
      default: index = pc_idx ^ hist_ext;
    endcase
  end

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign pop      = result && (outstanding != '0);
  assign accept   = request && (!full || pop);
  assign pop_idx  = fifo_idx[rd_ptr];
  assign pop_pred = fifo_pred[rd_ptr];
  assign old_ctr  = ctr_table[pop_idx];
  assign new_pred = ctr_table[index][CTR_BITS-1];

  // Saturating counter step for the entry being resolved.
  always_comb begin
    new_ctr = old_ctr;
    if (taken) begin
      if (old_ctr != CTR_MAX) new_ctr = old_ctr + CTR_BITS'(1);
    end else begin
      if (old_ctr != '0) new_ctr = old_ctr - CTR_BITS'(1);
    end
  end

  // Shift in the resolved outcome; truncation handles HIST_BITS == 1.
  assign hist_next = HIST_BITS'({history, taken});

  always_comb begin
    occ_next = outstanding;
    case ({accept, pop})
      2'b10:   occ_next = outstanding + (PTR_BITS+1)'(1);
      2'b01:   occ_next = outstanding - (PTR_BITS+1)'(1);
      default: occ_next = outstanding;
    endcase
  end

  // Counter table and history; the read for a prediction sees the
  // pre-edge value because the write is non-blocking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) ctr_table[i] <= CTR_INIT;
      history <= '0;
    end else if (pop) begin
      ctr_table[pop_idx] <= new_ctr;
      history            <= hist_next;
    end
  end

  // FIFO payload needs no reset; pointers and occupancy qualify it.
  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_idx[wr_ptr]  <= index;
      fifo_pred[wr_ptr] <= new_pred;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      full        <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_BITS'(1);
      outstanding <= occ_next;
      full        <= (occ_next == DEPTH_OCC);
    end
  end

  // Output prediction register and mispredict counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prediction     <= CTR_INIT[CTR_BITS-1];
      pred_valid     <= 1'b0;
      mispredict_cnt <= '0;
    end else begin
      pred_valid <= accept;
      if (accept) prediction <= new_pred;
      if (pop && (pop_pred != taken) && (mispredict_cnt != CNT_MAX))
        mispredict_cnt <= mispredict_cnt + CNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// tb_gshare_predictor
//   Drives a bimodal (index 0) and a gshare (index 1) predictor with the
//   same stimulus. A behavioural model pushes the expected prediction into
//   a per-instance scoreboard whenever a request is accepted; the entry is
//   popped and compared when the DUT raises pred_valid.
module tb_gshare_predictor;

  logic        clk;
  logic        rst_n;
  logic        request;
  logic [31:0] pc;
  logic        result;
  logic        taken;

  logic        pred  [2];
  logic        pv    [2];
  logic        fl    [2];
  logic [2:0]  outst [2];
  logic [15:0] mc    [2];

  int checks;
  int errors;

  int mtab  [2][256];
  int mhist [2];
  int mcnt  [2];
  int fIdx  [2][$];
  bit fP    [2][$];
  bit sbq   [2][$];
  bit lastPred [2];
  bit expValid [2];

  gshare_predictor #(.MODE(0)) dut_bim (
    .clk(clk), .rst_n(rst_n), .request(request), .pc(pc),
    .result(result), .taken(taken), .prediction(pred[0]),
    .pred_valid(pv[0]), .full(fl[0]), .outstanding(outst[0]),
    .mispredict_cnt(mc[0])
  );

  gshare_predictor #(.MODE(2)) dut_gsh (
    .clk(clk), .rst_n(rst_n), .request(request), .pc(pc),
    .result(result), .taken(taken), .prediction(pred[1]),
    .pred_valid(pv[1]), .full(fl[1]), .outstanding(outst[1]),
    .mispredict_cnt(mc[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) mtab[k][i] = 3;
      mhist[k] = 0;
      mcnt[k]  = 0;
      fIdx[k].delete();
      fP[k].delete();
      sbq[k].delete();
      lastPred[k] = 1'b1;
      expValid[k] = 1'b0;
    end
  endtask

  // One edge of the reference model, evaluated from pre-edge state.
  task automatic modelStep(input int k, input bit req, input logic [31:0] p,
                           input bit res, input bit tkn);
    int idx;
    int oIdx;
    bit pb;
    bit oP;
    bit doPop;
    bit acc;
    idx = 0;
    pb  = 1'b0;
    doPop = res && (fIdx[k].size() > 0);
    acc   = req && ((fIdx[k].size() < 4) || doPop);
    expValid[k] = acc;
    if (acc) begin
      idx = int'(p[9:2]);
      if (k == 1) idx = idx ^ mhist[k];
      pb = (mtab[k][idx] >= 2);
    end
    if (doPop) begin
      oIdx = fIdx[k].pop_front();
      oP   = fP[k].pop_front();
      if (tkn) begin
        if (mtab[k][oIdx] < 3) mtab[k][oIdx]++;
      end else begin
        if (mtab[k][oIdx] > 0) mtab[k][oIdx]--;
      end
      mhist[k] = ((mhist[k] << 1) | int'(tkn)) & 255;
      if ((oP != tkn) && (mcnt[k] < 65535)) mcnt[k]++;
    end
    if (acc) begin
      fIdx[k].push_back(idx);
      fP[k].push_back(pb);
      sbq[k].push_back(pb);
    end
  endtask

  // Drive one cycle of stimulus, step the model and compare outputs.
  task automatic applyStimulus(input bit req, input logic [31:0] p,
                               input bit res, input bit tkn);
    bit exp;
    @(negedge clk);
    request = req;
    pc      = p;
    result  = res;
    taken   = tkn;
    @(posedge clk);
    for (int k = 0; k < 2; k++) modelStep(k, req, p, res, tkn);
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("pred_valid[%0d]", k), int'(pv[k]), int'(expValid[k]));
      if (pv[k]) begin
        if (sbq[k].size() == 0) begin
          checkOutput($sformatf("sb_underflow[%0d]", k), sbq[k].size(), 1);
        end else begin
          exp = sbq[k].pop_front();
          checkOutput($sformatf("prediction[%0d]", k), int'(pred[k]), int'(exp));
          lastPred[k] = exp;
        end
      end else begin
        checkOutput($sformatf("pred_hold[%0d]", k), int'(pred[k]), int'(lastPred[k]));
      end
      checkOutput($sformatf("outstanding[%0d]", k), int'(outst[k]), fIdx[k].size());
      checkOutput($sformatf("full[%0d]", k), int'(fl[k]), int'(fIdx[k].size() == 4));
      checkOutput($sformatf("mispredict[%0d]", k), int'(mc[k]), mcnt[k]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted away from any clock edge.
  task automatic doReset();
    @(negedge clk);
    request = 1'b0;
    result  = 1'b0;
    taken   = 1'b0;
    #2 rst_n = 1'b0;
    modelReset();
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("rst_pred[%0d]", k), int'(pred[k]), 1);
      checkOutput($sformatf("rst_pv[%0d]", k), int'(pv[k]), 0);
      checkOutput($sformatf("rst_outst[%0d]", k), int'(outst[k]), 0);
      checkOutput($sformatf("rst_full[%0d]", k), int'(fl[k]), 0);
      checkOutput($sformatf("rst_mcnt[%0d]", k), int'(mc[k]), 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) begin
      if (fIdx[0].size() > 0) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b1;
    request = 1'b0;
    pc      = 32'h0;
    result  = 1'b0;
    taken   = 1'b0;
    modelReset();
    doReset();

    // First prediction after reset comes from an untouched entry.
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0);
    checkOutput("first_pred", int'(pred[0]), 1);
    checkOutput("first_outst", int'(outst[0]), 1);
    idle(1);
    checkOutput("first_pv_drop", int'(pv[0]), 0);
    drain();

    // Walk the pc=0x40 counter down to zero and back up.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    end
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);
    checkOutput("sat_low_pred", int'(pred[0]), 0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    end
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);
    checkOutput("sat_up_pred", int'(pred[0]), 1);
    drain();

    // Fill the FIFO; the fifth request bounces, then push+pop together.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h200 + 32'(4 * i), 1'b0, 1'b0);
    checkOutput("full_pv", int'(pv[0]), 0);
    checkOutput("full_flag", int'(fl[0]), 1);
    checkOutput("full_outst", int'(outst[0]), 4);
    applyStimulus(1'b1, 32'h210, 1'b1, 1'b0);
    checkOutput("full_swap_pv", int'(pv[0]), 1);
    checkOutput("full_swap_outst", int'(outst[0]), 4);
    drain();

    // Resolve with nothing outstanding, then read the same entry.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);
    drain();

    // Gshare: history becomes 110, so pc=0 reads entry 6.
    doReset();
    applyStimulus(1'b1, 32'h300, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h304, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h308, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("gsh_hist_mcnt", int'(mc[1]), 1);
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
    checkOutput("gsh_entry6_pred", int'(pred[1]), 1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("gsh_mcnt_inc", int'(mc[1]), 2);

    // Reset with three predictions in flight.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);
    checkOutput("pre_rst_outst", int'(outst[0]), 3);
    doReset();
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);
    checkOutput("post_rst_a", int'(pred[0]), 1);
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0);
    checkOutput("post_rst_b", int'(pred[0]), 1);
    applyStimulus(1'b1, 32'h300, 1'b0, 1'b0);
    checkOutput("post_rst_c", int'(pred[0]), 1);
    drain();

    // Mixed traffic over a small pc range to force aliasing.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), {26'd0, 4'($urandom_range(0, 15)), 2'b00},
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
Parametrised successor to the single 2-bit saturating-counter branch predictor. It holds a table of N-bit saturating counters. Each table is indexed by PC (bimodal mode), by global branch history (global mode), or by their XOR (gshare mode). Up to DEPTH predictions may be outstanding; an in-order FIFO carries each one's table index and predicted direction until its result arrives. It sits between fetch (request/pc) and branch resolution (result/taken) and also exports a saturating mispredict count.

Parameters:
PC_BITS, 32, width of pc input
IDX_BITS, 8, log2 of table entries (256 entries)
HIST_BITS, 8, global history length; must be <= IDX_BITS
CTR_BITS, 2, counter width; must be >= 1
CTR_INIT, 2'b11 (all ones), per-entry counter reset value, CTR_BITS wide
DEPTH, 4, outstanding-prediction FIFO depth; power of two, >= 2
MODE, 2, 0 = bimodal, 1 = global, 2 = gshare
CNT_BITS, 16, mispredict counter width

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
request  input  1  predict the branch at pc this cycle
pc  input  PC_BITS  branch address, sampled when request=1
result  input  1  resolve the oldest outstanding prediction this cycle
taken  input  1  actual direction, sampled when result=1
prediction  output  1  predicted direction, registered
pred_valid  output  1  one-cycle pulse: prediction updated for an accepted request
full  output  1  FIFO holds DEPTH entries
outstanding  output  log2(DEPTH)+1  current FIFO occupancy
mispredict_cnt  output  CNT_BITS  saturating count of resolved mispredictions

Behaviour:
- Reset (async, rst_n=0):
  - every table entry = CTR_INIT; history = 0; FIFO empty; outstanding = 0; full = 0.
  - prediction = CTR_INIT MSB (1 by default); pred_valid = 0; mispredict_cnt = 0.
  - Reset mid-operation discards all outstanding entries; no table write completes.
- Index:
  - bimodal: pc[IDX_BITS+1:2].
  - global: history zero-extended to IDX_BITS.
  - gshare: pc[IDX_BITS+1:2] XOR zero-extended history.
  - History here is the value before this edge's update.
- Request acceptance: request=1 and (not full, or result=1 with non-empty FIFO).
- Accepted request, same edge:
  - prediction <= MSB of table[index], using the table value before any same-edge write.
  - pred_valid <= 1.
  - push {index, predicted bit} to the FIFO.
- Rejected request (full, no pop): prediction holds; pred_valid <= 0; no push. Requester must retry.
- No request: pred_valid <= 0; prediction holds.
- Resolve: result=1 with FIFO non-empty pops the oldest entry {idx, p}, then:
  - taken=1: table[idx] += 1, saturating at all ones.
  - taken=0: table[idx] -= 1, saturating at 0.
  - history <= {history[HIST_BITS-2:0], taken}; for HIST_BITS=1, history <= taken.
  - if p != taken, mispredict_cnt += 1, saturating at all ones.
- result=1 with FIFO empty: ignored; no table, history or counter change.
- Simultaneous accepted request and resolve:
  - push and pop both occur; outstanding is unchanged.
  - If both address the same entry, the prediction uses the old counter value and the write still lands.
- Prediction latency: 1 cycle (visible the cycle after the request edge).
- Resolve latency: the updated table entry is visible to a request on the following edge.
- outstanding / full are registered and reflect post-edge occupancy; full = (outstanding == DEPTH).
- FIFO pointers wrap modulo DEPTH; occupancy never exceeds DEPTH.
- MODE is static; behaviour for other MODE values: treated as gshare.

Test Plan:
- Reset, then request pc=0x100 -> next cycle prediction=1, pred_valid=1, outstanding=1; following cycle pred_valid=0.
- Saturation, MODE=0, pc=0x40, counter ops via result:
  - 3 resolves taken=0 -> counter 11→10→01→00.
  - Next request -> prediction=0.
  - 4th not-taken resolve -> counter stays 00.
  - 2 taken resolves -> counter 10; request -> prediction=1.
- Full, DEPTH=4: 5 consecutive requests, no result -> 5th gives pred_valid=0, full=1, outstanding=4. Then request+result in the same cycle -> pred_valid=1, outstanding stays 4.
- Spurious resolve: result=1 with outstanding=0 -> table, history and mispredict_cnt all unchanged.
- Gshare, MODE=2:
  - Resolves T, T, N -> history=0b110.
  - Request pc=0x0 -> reads entry 6.
  - Outstanding prediction 1 resolved taken=0 -> mispredict_cnt increments by 1.
- Reset mid-operation: outstanding=3, mispredict_cnt=2, rst_n=0 for any duration -> outstanding=0, mispredict_cnt=0, prediction=1, all entries back to CTR_INIT (verify by bimodal requests to 3 PCs).
